// File: rtl/systolic_pkg.sv
// Shared types, default sizes and width helpers for the NxN systolic multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package systolic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   localparam int unsigned DEF_N      = 8;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ACC_W  = 32;
   localparam int unsigned DEF_K_MAX  = 256;

   // Width able to hold 0..k_max inclusive.
   function automatic int unsigned k_len_w(input int unsigned k_max);
      return $clog2(k_max + 1);
   endfunction

   // Flush counter runs 0..2n-2.
   function automatic int unsigned flush_cnt_w(input int unsigned n);
      return $clog2(2 * n - 1);
   endfunction

   // Row index 0..n-1; at least one bit.
   function automatic int unsigned row_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: acc += a*b, forwards a right and b down.
// Latency: one register on the a/b forwarding path; accumulate lands on the same edge.
// Backpressure: none of its own; everything holds while en=0.
// Ports: clk, rst (async active-low), en (global step), clr (sync accumulator clear),
//        is_signed (operand mode), a_in/b_in (operands), a_out/b_out (forwarded), acc.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ACC_W  = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ACC_W-1:0]  acc
);

   localparam int unsigned PW = 2 * DATA_W;

   logic [DATA_W-1:0] a_q, b_q;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [PW-1:0]     a_ext, b_ext, prod;
   logic [ACC_W-1:0]  prod_ext;

   // Extending both operands to 2*DATA_W and keeping the low 2*DATA_W product
   // bits gives the exact signed or unsigned product: it always fits.
   assign a_ext = {{DATA_W{is_signed & a_in[DATA_W-1]}}, a_in};
   assign b_ext = {{DATA_W{is_signed & b_in[DATA_W-1]}}, b_in};
   assign prod  = a_ext * b_ext;

   generate
      if (ACC_W > PW) begin : g_ext
         assign prod_ext = {{(ACC_W - PW){is_signed & prod[PW-1]}}, prod};
      end else begin : g_noext
         assign prod_ext = prod;
      end
   endgenerate

   // Wraps modulo 2^ACC_W by construction.
   assign acc_d = acc_q + prod_ext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         if (clr) begin
            acc_q <= '0;
         end else if (en) begin
            acc_q <= acc_d;
         end
         if (en) begin
            a_q <= a_in;
            b_q <= b_in;
         end
      end
   end

   assign a_out = a_q;
   assign b_out = b_q;
   assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_mat_mult_nxn.sv
// NxN output-stationary systolic multiplier C = A(NxK) * B(KxN), run-time K/sign/keep.
// Latency: done/first row 2N-1 cycles after the last consumed A/B beat.
// Backpressure: A/B beat consumed only when both valid (array freezes otherwise); rows held until c_ready.
// Ports: clk, rst (async active-low); start/k_len/is_signed/acc_keep/ready job control; done pulse;
//        a_valid/a_ready/a_in and b_valid/b_ready/b_in operand streams; c_valid/c_ready/c_out/c_row results.
module systolic_array_mat_mult_nxn
   import systolic_pkg::*;
#(
   parameter int unsigned N      = DEF_N,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ACC_W  = DEF_ACC_W,
   parameter int unsigned K_MAX  = DEF_K_MAX,
   localparam int unsigned KW    = k_len_w(K_MAX),
   localparam int unsigned RW    = row_w(N)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [KW-1:0]              k_len,
   input  logic                       is_signed,
   input  logic                       acc_keep,
   output logic                       ready,
   output logic                       done,
   input  logic                       a_valid,
   output logic                       a_ready,
   input  logic [N-1:0][DATA_W-1:0]   a_in,
   input  logic                       b_valid,
   output logic                       b_ready,
   input  logic [N-1:0][DATA_W-1:0]   b_in,
   output logic                       c_valid,
   input  logic                       c_ready,
   output logic [N-1:0][ACC_W-1:0]    c_out,
   output logic [RW-1:0]              c_row
);

   localparam int unsigned FW = flush_cnt_w(N);

   state_e          state_q, state_d;
   logic [KW-1:0]   k_len_q, k_len_d;
   logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
   logic [RW-1:0]   c_row_q, c_row_d;
   logic            is_signed_q, is_signed_d;
   logic            done_q, done_d;

   logic            beat_fire;
   logic            en;
   logic            clr_acc;

   logic [N-1:0][DATA_W-1:0]         a_edge, b_edge;
   logic [N-1:0][DATA_W-1:0]         a_west, b_north;
   logic [N-1:0][N-1:0][DATA_W-1:0]  a_pe_in, b_pe_in;
   logic [N-1:0][N-1:0][DATA_W-1:0]  a_fwd, b_fwd;
   logic [N-1:0][N-1:0][ACC_W-1:0]   acc;
   logic [N-1:0][DATA_W-1:0]         a_east_unused, b_south_unused;

   assign beat_fire = (state_q == ST_LOAD) && a_valid && b_valid;
   // The whole array steps together: on consumed beats and every FLUSH cycle.
   assign en        = beat_fire || (state_q == ST_FLUSH);
   assign clr_acc   = (state_q == ST_IDLE) && start && !acc_keep;

   // Zeros enter the edges whenever no beat is being consumed (FLUSH padding).
   assign a_edge = beat_fire ? a_in : '0;
   assign b_edge = beat_fire ? b_in : '0;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d     = state_q;
      k_len_d     = k_len_q;
      beat_cnt_d  = beat_cnt_q;
      flush_cnt_d = flush_cnt_q;
      c_row_d     = c_row_q;
      is_signed_d = is_signed_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               k_len_d     = k_len;
               is_signed_d = is_signed;
               beat_cnt_d  = '0;
               if (k_len == '0) begin
                  state_d = ST_DRAIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (beat_fire) begin
               if (beat_cnt_q == k_len_q - KW'(1)) begin
                  state_d     = ST_FLUSH;
                  beat_cnt_d  = '0;
                  flush_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + KW'(1);
               end
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == FW'(2 * N - 2)) begin
               state_d = ST_DRAIN;
               done_d  = 1'b1;
            end else begin
               flush_cnt_d = flush_cnt_q + FW'(1);
            end
         end
         ST_DRAIN: begin
            if (c_ready) begin
               if (c_row_q == RW'(N - 1)) begin
                  state_d = ST_IDLE;
                  c_row_d = '0;
               end else begin
                  c_row_d = c_row_q + RW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         k_len_q     <= '0;
         beat_cnt_q  <= '0;
         flush_cnt_q <= '0;
         c_row_q     <= '0;
         is_signed_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_len_q     <= k_len_d;
         beat_cnt_q  <= beat_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         c_row_q     <= c_row_d;
         is_signed_q <= is_signed_d;
         done_q      <= done_d;
      end
   end

   // ---------------------------------------------------------------- skew
   // Row i of A and column i of B are delayed i steps so matching k meet in PE(i,j).
   generate
      for (genvar i = 0; i < N; i++) begin : g_skew
         if (i == 0) begin : g_direct
            assign a_west[0]  = a_edge[0];
            assign b_north[0] = b_edge[0];
         end else begin : g_dly
            logic [i-1:0][DATA_W-1:0] a_sh_q, b_sh_q;
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  a_sh_q <= '0;
                  b_sh_q <= '0;
               end else if (en) begin
                  a_sh_q[0] <= a_edge[i];
                  b_sh_q[0] <= b_edge[i];
                  for (int s = 1; s < i; s++) begin
                     a_sh_q[s] <= a_sh_q[s-1];
                     b_sh_q[s] <= b_sh_q[s-1];
                  end
               end
            end
            assign a_west[i]  = a_sh_q[i-1];
            assign b_north[i] = b_sh_q[i-1];
         end
      end
   endgenerate

   // ---------------------------------------------------------------- PE grid
   generate
      for (genvar i = 0; i < N; i++) begin : g_row
         for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
               assign a_pe_in[i][j] = a_west[i];
            end else begin : g_a_link
               assign a_pe_in[i][j] = a_fwd[i][j-1];
            end
            if (i == 0) begin : g_b_edge
               assign b_pe_in[i][j] = b_north[j];
            end else begin : g_b_link
               assign b_pe_in[i][j] = b_fwd[i-1][j];
            end

            systolic_pe #(
               .DATA_W (DATA_W),
               .ACC_W  (ACC_W)
            ) u_pe (
               .clk       (clk),
               .rst       (rst),
               .en        (en),
               .clr       (clr_acc),
               .is_signed (is_signed_q),
               .a_in      (a_pe_in[i][j]),
               .b_in      (b_pe_in[i][j]),
               .a_out     (a_fwd[i][j]),
               .b_out     (b_fwd[i][j]),
               .acc       (acc[i][j])
            );
         end
         // Operands falling off the far edges go nowhere.
         assign a_east_unused[i]  = a_fwd[i][N-1];
         assign b_south_unused[i] = b_fwd[N-1][i];
      end
   endgenerate

   // ---------------------------------------------------------------- outputs
   assign ready   = (state_q == ST_IDLE);
   assign done    = done_q;
   assign a_ready = (state_q == ST_LOAD);
   assign b_ready = (state_q == ST_LOAD);
   assign c_valid = (state_q == ST_DRAIN);
   assign c_row   = c_row_q;
   assign c_out   = (state_q == ST_DRAIN) ? acc[c_row_q] : '0;

endmodule

// File: tb/tb_systolic_array_mat_mult_nxn.sv
module tb_systolic_array_mat_mult_nxn;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, start, is_signed, acc_keep, a_valid, b_valid, c_ready;
   logic [8:0]      k_len;
   logic [7:0][7:0] a_bus, b_bus;
   int              sel;
   logic [2:0]      start_v;

   assign start_v = {start && (sel == 2), start && (sel == 1), start && (sel == 0)};

   // Three instances: N=8/ACC32, N=4/ACC32, N=2/ACC16. Only the selected one gets start.
   logic rdy8, dn8, ar8, br8, cv8; logic [2:0] row8; logic [7:0][31:0] c8;
   logic rdy4, dn4, ar4, br4, cv4; logic [1:0] row4; logic [3:0][31:0] c4;
   logic rdy2, dn2, ar2, br2, cv2; logic       row2; logic [1:0][15:0] c2;

   systolic_array_mat_mult_nxn #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start_v[0]), .k_len(k_len), .is_signed(is_signed),
      .acc_keep(acc_keep), .ready(rdy8), .done(dn8), .a_valid(a_valid), .a_ready(ar8),
      .a_in(a_bus), .b_valid(b_valid), .b_ready(br8), .b_in(b_bus), .c_valid(cv8),
      .c_ready(c_ready), .c_out(c8), .c_row(row8));

   systolic_array_mat_mult_nxn #(.N(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start_v[1]), .k_len(k_len), .is_signed(is_signed),
      .acc_keep(acc_keep), .ready(rdy4), .done(dn4), .a_valid(a_valid), .a_ready(ar4),
      .a_in(a_bus[3:0]), .b_valid(b_valid), .b_ready(br4), .b_in(b_bus[3:0]), .c_valid(cv4),
      .c_ready(c_ready), .c_out(c4), .c_row(row4));

   systolic_array_mat_mult_nxn #(.N(2), .ACC_W(16)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .k_len(k_len), .is_signed(is_signed),
      .acc_keep(acc_keep), .ready(rdy2), .done(dn2), .a_valid(a_valid), .a_ready(ar2),
      .a_in(a_bus[1:0]), .b_valid(b_valid), .b_ready(br2), .b_in(b_bus[1:0]), .c_valid(cv2),
      .c_ready(c_ready), .c_out(c2), .c_row(row2));

   // Observed outputs of the selected instance.
   logic             o_rdy, o_done, o_ar, o_br, o_cv;
   int               o_row;
   logic [7:0][31:0] o_c;

   always_comb begin
      o_c = '0; o_rdy = 1'b0; o_done = 1'b0; o_ar = 1'b0; o_br = 1'b0; o_cv = 1'b0; o_row = 0;
      case (sel)
         0: begin
            o_rdy = rdy8; o_done = dn8; o_ar = ar8; o_br = br8; o_cv = cv8;
            o_row = int'(row8); o_c = c8;
         end
         1: begin
            o_rdy = rdy4; o_done = dn4; o_ar = ar4; o_br = br4; o_cv = cv4;
            o_row = int'(row4); o_c[3:0] = c4;
         end
         default: begin
            o_rdy = rdy2; o_done = dn2; o_ar = ar2; o_br = br2; o_cv = cv2;
            o_row = int'(row2); o_c[0] = {16'h0, c2[0]}; o_c[1] = {16'h0, c2[1]};
         end
      endcase
   end

   typedef struct {
      int          sel;
      int          k;
      bit          sgn;
      bit          keep;
      int          a_code;
      int          b_code;
      int          koff;
      bit          use_const;
      logic [31:0] exp_const;
      bit          stall;
      bit          hold;
      bit          sid;       // pulse start during DRAIN
   } job_t;

   job_t jobs[10];
   int   acc_m[3][8][8];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   function automatic int n_of(input int s);
      return (s == 0) ? 8 : (s == 1) ? 4 : 2;
   endfunction

   function automatic logic [7:0] pat(input int code, input int r, input int c);
      logic [7:0] v;
      case (code)
         0: v = (r == c) ? 8'd1 : 8'd0;
         1: v = 8'(r * 8 + c);
         2: v = 8'h80;
         3: v = 8'hFF;
         4: v = 8'h01;
         5: v = 8'h7F;
         default: v = 8'(r * 37 + c * 11 + 5);
      endcase
      return v;
   endfunction

   function automatic int sx(input bit s, input logic [7:0] v);
      return s ? int'($signed(v)) : int'({24'h0, v});
   endfunction

   function automatic logic [31:0] exp_val(input job_t j, input int r, input int c);
      if (j.use_const) return j.exp_const;
      if (j.sel == 2) return 32'(acc_m[2][r][c]) & 32'h0000FFFF;
      return 32'(acc_m[j.sel][r][c]);
   endfunction

   task automatic start_job(input job_t j);
      int n;
      n = n_of(j.sel);
      sel = j.sel;
      if (!j.keep) begin
         for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) acc_m[j.sel][r][c] = 0;
      end
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            for (int k = 0; k < j.k; k++)
               acc_m[j.sel][r][c] += sx(j.sgn, pat(j.a_code, r, k + j.koff)) *
                                     sx(j.sgn, pat(j.b_code, k + j.koff, c));
      start = 1'b1; k_len = 9'(j.k); is_signed = j.sgn; acc_keep = j.keep;
      tick();
      start = 1'b0;
   endtask

   task automatic feed_beats(input job_t j);
      int n, beat, guard;
      bit av, bv;
      n = n_of(j.sel);
      beat = 0; guard = 0;
      while (beat < j.k && guard < 200) begin
         if (j.stall) begin
            av = (guard == 0) ? 1'b1 : 1'($urandom_range(1));
            bv = (guard == 0) ? 1'b0 : 1'($urandom_range(1));
         end else begin
            av = 1'b1; bv = 1'b1;
         end
         a_valid = av; b_valid = bv;
         a_bus = {$urandom, $urandom};
         b_bus = {$urandom, $urandom};
         if (av && bv) begin
            for (int i = 0; i < n; i++) begin
               a_bus[i] = pat(j.a_code, i, beat + j.koff);
               b_bus[i] = pat(j.b_code, beat + j.koff, i);
            end
         end
         chk("load_ready", 32'({o_ar, o_br}), 32'd3);
         tick();
         if (av && bv) beat++;
         guard++;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      if (beat < j.k) chk("beat_budget", 32'(beat), 32'(j.k));
      if (j.k > 0) chk("ready_drop", 32'({o_ar, o_br}), 32'd0);
   endtask

   task automatic finish_job(input job_t j);
      int n, lat;
      n = n_of(j.sel);
      lat = 0;
      while (!o_done && lat < 100) begin
         tick();
         lat++;
      end
      chk("done_latency", 32'(lat), (j.k == 0) ? 32'd0 : 32'(2 * n - 1));
      c_ready = 1'b1;
      for (int r = 0; r < n; r++) begin
         chk("c_valid", 32'(o_cv), 32'd1);
         chk("c_row", 32'(o_row), 32'(r));
         for (int c = 0; c < n; c++) chk("c_out", o_c[c], exp_val(j, r, c));
         if (j.hold && r == 2) begin
            c_ready = 1'b0;
            for (int w = 0; w < 5; w++) begin
               tick();
               chk("hold_row", 32'(o_row), 32'(r));
               chk("hold_out", o_c[n-1], exp_val(j, r, n - 1));
            end
            c_ready = 1'b1;
         end
         if (j.sid && r == 1) begin
            c_ready = 1'b0;
            start = 1'b1; k_len = 9'd3;
            tick();
            start = 1'b0;
            chk("drain_start_cvalid", 32'(o_cv), 32'd1);
            chk("drain_start_aready", 32'(o_ar), 32'd0);
            c_ready = 1'b1;
         end
         tick();
         if (r == 0) chk("done_pulse", 32'(o_done), 32'd0);
      end
      c_ready = 1'b0;
      chk("idle_after_drain", 32'({o_rdy, o_cv}), 32'd2);
      chk("row_reset", 32'(o_row), 32'd0);
      tick();
      chk("still_idle", 32'({o_rdy, o_ar}), 32'd2);
   endtask

   task automatic run_job(input job_t j);
      sel = j.sel;
      if (j.stall) begin
         // Beats offered in IDLE must not be consumed.
         a_valid = 1'b1; b_valid = 1'b1;
         a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
         tick();
         chk("idle_a_ready", 32'(o_ar), 32'd0);
         a_valid = 1'b0; b_valid = 1'b0;
      end
      start_job(j);
      feed_beats(j);
      finish_job(j);
   endtask

   job_t jr, jk;

   initial begin
      //            sel k sgn keep a  b  off cst exp           stl hld sid
      jobs[0] = '{0, 8, 0, 0, 0, 1, 0, 0, 32'd0,        0, 0, 0};
      jobs[1] = '{1, 4, 1, 0, 2, 2, 0, 1, 32'd65536,    0, 0, 0};
      jobs[2] = '{1, 4, 0, 0, 2, 2, 0, 1, 32'd65536,    0, 0, 0};
      jobs[3] = '{1, 4, 1, 0, 3, 4, 0, 1, 32'hFFFFFFFC, 0, 0, 0};
      jobs[4] = '{1, 4, 0, 0, 3, 4, 0, 1, 32'd1020,     0, 0, 0};
      jobs[5] = '{1, 3, 1, 0, 6, 6, 0, 0, 32'd0,        0, 0, 0};
      jobs[6] = '{1, 2, 1, 1, 6, 6, 3, 0, 32'd0,        0, 0, 0};
      jobs[7] = '{1, 0, 0, 0, 6, 6, 0, 1, 32'd0,        0, 0, 0};
      jobs[8] = '{1, 4, 1, 0, 6, 6, 0, 0, 32'd0,        1, 1, 0};
      jobs[9] = '{2, 5, 1, 0, 5, 5, 0, 1, 32'd15109,    0, 0, 1};

      rst = 1'b0; start = 1'b0; is_signed = 1'b0; acc_keep = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0; c_ready = 1'b0; k_len = '0;
      a_bus = '0; b_bus = '0; sel = 0;
      for (int s = 0; s < 3; s++)
         for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) acc_m[s][r][c] = 0;
      tick(); tick();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk("rst_ready", 32'(o_rdy), 32'd1);
         chk("rst_done", 32'(o_done), 32'd0);
         chk("rst_ab_ready", 32'({o_ar, o_br}), 32'd0);
         chk("rst_c_valid", 32'(o_cv), 32'd0);
         chk("rst_c_row", 32'(o_row), 32'd0);
         chk("rst_c_out0", o_c[0], 32'd0);
      end
      rst = 1'b1;
      tick();

      for (int t = 0; t < 10; t++) run_job(jobs[t]);

      // Reset while in FLUSH, then a keep job must start from zero accumulators.
      jr = '{1, 4, 1, 0, 6, 6, 0, 0, 32'd0, 0, 0, 0};
      start_job(jr);
      feed_beats(jr);
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) acc_m[1][r][c] = 0;
      chk("mid_rst_ready", 32'(o_rdy), 32'd1);
      chk("mid_rst_c_valid", 32'(o_cv), 32'd0);
      chk("mid_rst_a_ready", 32'(o_ar), 32'd0);
      tick();
      jk = '{1, 4, 1, 1, 1, 6, 0, 0, 32'd0, 0, 0, 0};
      run_job(jk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
